// File: rtl/myo_telemetry_pkg.sv
`default_nettype none
// ============================================================================
// Module : myo_telemetry_pkg
// Brief  : Shared constants for the MYO telemetry FIFO (register map, record
//          format, serializer state encoding).
// Rev    : 1.0  initial release
// ============================================================================
package myo_telemetry_pkg;

    localparam int          REC_WORDS  = 4;
    localparam logic [7:0]  REC_MARKER = 8'hA5;
    localparam logic [31:0] BAD_ADDR   = 32'hDEADBEEF;

    // Read map
    localparam logic [7:0] ADDR_DATA    = 8'h00;
    localparam logic [7:0] ADDR_LEVEL   = 8'h01;
    localparam logic [7:0] ADDR_DROPPED = 8'h02;
    localparam logic [7:0] ADDR_CTRL    = 8'h03;
    localparam logic [7:0] ADDR_MASK    = 8'h04;

    // Write map
    localparam logic [7:0] WADDR_CTRL      = 8'h00;
    localparam logic [7:0] WADDR_DROPPED   = 8'h02;
    localparam logic [7:0] WADDR_THRESHOLD = 8'h03;
    localparam logic [7:0] WADDR_MASK      = 8'h04;

    // Serializer states
    typedef logic [2:0] ser_state_t;
    localparam ser_state_t SER_IDLE = 3'd0;
    localparam ser_state_t SER_W0   = 3'd1;
    localparam ser_state_t SER_W1   = 3'd2;
    localparam ser_state_t SER_W2   = 3'd3;
    localparam ser_state_t SER_W3   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/myo_telemetry_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module : telemetry_ram
// Brief  : Simple dual-port RAM, one write port, one registered read port.
// Rev    : 1.0  initial release
// ============================================================================
module telemetry_ram
    import myo_telemetry_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read of a word written on the same edge returns the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/myo_telemetry_fifo.sv
`default_nettype none
// ============================================================================
// Module : myo_telemetry_fifo
// Brief  : Captures 4-word per-motor telemetry records into a word FIFO that
//          the HPS drains over an Avalon-style register interface.
// Rev    : 1.0  initial release
// ============================================================================
module myo_telemetry_fifo
    import myo_telemetry_pkg::*;
#(
    parameter int NUMBER_OF_MOTORS = 6,
    parameter int FIFO_DEPTH       = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [7:0]  sample_motor,
    input  logic [31:0] position,
    input  logic [15:0] velocity,
    input  logic [15:0] current,
    input  logic [15:0] displacement,
    input  logic [15:0] pwm_ref,
    input  logic [7:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        fifo_irq
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_lw = c_aw + 1;
    localparam logic [c_lw-1:0] c_depth = c_lw'(FIFO_DEPTH);

    ser_state_t      state_q, state_d;
    logic            enable_q, enable_d;
    logic [31:0]     mask_q, mask_d;
    logic [15:0]     threshold_q, threshold_d;
    logic [31:0]     dropped_q, dropped_d;
    logic [15:0]     seq_q, seq_d;
    logic [c_lw-1:0] level_q, level_d;
    logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
    logic            irq_q, irq_d;
    logic            rd_phase_q, rd_phase_d;
    logic            rd_empty_q, rd_empty_d;
    logic [15:0]     rec_seq_q, rec_seq_d;
    logic [7:0]      rec_motor_q, rec_motor_d;
    logic [31:0]     rec_pos_q, rec_pos_d;
    logic [31:0]     rec_vc_q, rec_vc_d;
    logic [31:0]     rec_dp_q, rec_dp_d;

    logic        w_flush;
    logic        w_motor_ok;
    logic        w_idle;
    logic        w_room;
    logic        w_capture_req;
    logic        w_accept;
    logic        w_drop;
    logic        w_push;
    logic        w_pop;
    logic        w_rd_start;
    logic        w_rd_done;
    logic        w_data_ok;
    logic [31:0] w_push_data;
    logic [31:0] w_ram_rdata;

    assign w_flush       = write && (address == WADDR_CTRL) && writedata[1];
    assign w_motor_ok    = ({24'd0, sample_motor} < 32'(NUMBER_OF_MOTORS)) && mask_q[sample_motor[4:0]];
    assign w_idle        = (state_q == SER_IDLE);
    assign w_room        = (c_depth - level_q) >= c_lw'(REC_WORDS);
    assign w_capture_req = sample_valid && enable_q && w_motor_ok && !w_flush;
    assign w_accept      = w_capture_req && w_idle && w_room;
    assign w_drop        = w_capture_req && !(w_idle && w_room);
    assign w_push        = !w_idle && !w_flush;

    // Emptiness is latched in the first read cycle so a word landing on that
    // same edge is never returned (the RAM read already saw the old contents).
    assign w_rd_start  = read && !rd_phase_q;
    assign w_rd_done   = read && rd_phase_q;
    assign w_data_ok   = !rd_empty_q && (level_q != '0);
    assign w_pop       = w_rd_done && (address == ADDR_DATA) && w_data_ok && !w_flush;
    assign waitrequest = w_rd_start;
    assign fifo_irq    = irq_q;

    always_comb begin
        w_push_data = '0;
        case (state_q)
            SER_W0:  w_push_data = {REC_MARKER, rec_motor_q, rec_seq_q};
            SER_W1:  w_push_data = rec_pos_q;
            SER_W2:  w_push_data = rec_vc_q;
            SER_W3:  w_push_data = rec_dp_q;
            default: w_push_data = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        enable_d    = enable_q;
        mask_d      = mask_q;
        threshold_d = threshold_q;
        dropped_d   = dropped_q;
        seq_d       = seq_q;
        level_d     = level_q + c_lw'(w_push) - c_lw'(w_pop);
        wr_ptr_d    = w_push ? wr_ptr_q + c_aw'(1) : wr_ptr_q;
        rd_ptr_d    = w_pop  ? rd_ptr_q + c_aw'(1) : rd_ptr_q;
        irq_d       = 32'(level_q) >= 32'(threshold_q);
        rd_phase_d  = w_rd_start;
        rd_empty_d  = w_rd_start ? (level_q == '0) : rd_empty_q;
        rec_seq_d   = rec_seq_q;
        rec_motor_d = rec_motor_q;
        rec_pos_d   = rec_pos_q;
        rec_vc_d    = rec_vc_q;
        rec_dp_d    = rec_dp_q;

        case (state_q)
            SER_IDLE: if (w_accept) state_d = SER_W0;
            SER_W0:   state_d = SER_W1;
            SER_W1:   state_d = SER_W2;
            SER_W2:   state_d = SER_W3;
            SER_W3:   state_d = SER_IDLE;
            default:  state_d = SER_IDLE;
        endcase

        if (w_accept) begin
            seq_d       = seq_q + 16'd1;
            rec_seq_d   = seq_q;
            rec_motor_d = sample_motor;
            rec_pos_d   = position;
            rec_vc_d    = {velocity, current};
            rec_dp_d    = {displacement, pwm_ref};
        end

        if (w_drop && (dropped_q != '1)) begin
            dropped_d = dropped_q + 32'd1;
        end

        if (write) begin
            case (address)
                WADDR_CTRL:      enable_d    = writedata[0];
                WADDR_DROPPED:   dropped_d   = '0;
                WADDR_THRESHOLD: threshold_d = writedata[15:0];
                WADDR_MASK:      mask_d      = writedata;
                default:         ;
            endcase
        end

        // Flush discards stored words and any partially written record.
        if (w_flush) begin
            state_d  = SER_IDLE;
            level_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= SER_IDLE;
            enable_q    <= 1'b0;
            mask_q      <= '1;
            threshold_q <= 16'(FIFO_DEPTH / 2);
            dropped_q   <= '0;
            seq_q       <= '0;
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            irq_q       <= 1'b0;
            rd_phase_q  <= 1'b0;
            rd_empty_q  <= 1'b1;
            rec_seq_q   <= '0;
            rec_motor_q <= '0;
            rec_pos_q   <= '0;
            rec_vc_q    <= '0;
            rec_dp_q    <= '0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            mask_q      <= mask_d;
            threshold_q <= threshold_d;
            dropped_q   <= dropped_d;
            seq_q       <= seq_d;
            level_q     <= level_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            irq_q       <= irq_d;
            rd_phase_q  <= rd_phase_d;
            rd_empty_q  <= rd_empty_d;
            rec_seq_q   <= rec_seq_d;
            rec_motor_q <= rec_motor_d;
            rec_pos_q   <= rec_pos_d;
            rec_vc_q    <= rec_vc_d;
            rec_dp_q    <= rec_dp_d;
        end
    end

    always_comb begin
        readdata = '0;
        if (w_rd_done) begin
            case (address)
                ADDR_DATA:    readdata = w_data_ok ? w_ram_rdata : BAD_ADDR;
                ADDR_LEVEL:   readdata = 32'(level_q);
                ADDR_DROPPED: readdata = dropped_q;
                ADDR_CTRL:    readdata = {threshold_q, 14'd0, !w_idle, enable_q};
                ADDR_MASK:    readdata = mask_q;
                default:      readdata = BAD_ADDR;
            endcase
        end
    end

    telemetry_ram #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (c_aw)
    ) u_ram (
        .clk   (clock),
        .we    (w_push),
        .waddr (wr_ptr_q),
        .wdata (w_push_data),
        .raddr (rd_ptr_q),
        .rdata (w_ram_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_myo_telemetry_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_myo_telemetry_fifo
// Brief  : Randomised and directed bench for myo_telemetry_fifo against a
//          queue-based reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_myo_telemetry_fifo;

    localparam int NM    = 6;
    localparam int DEPTH = 8;
    localparam logic [31:0] BAD = 32'hDEADBEEF;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sample_valid = 1'b0;
    logic [7:0]  sample_motor = '0;
    logic [31:0] position = '0;
    logic [15:0] velocity = '0, current = '0, displacement = '0, pwm_ref = '0;
    logic [7:0]  address = '0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        fifo_irq;

    always #5 clock = ~clock;

    myo_telemetry_fifo #(.NUMBER_OF_MOTORS(NM), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .sample_valid(sample_valid), .sample_motor(sample_motor),
        .position(position), .velocity(velocity), .current(current), .displacement(displacement),
        .pwm_ref(pwm_ref), .address(address), .write(write), .writedata(writedata), .read(read),
        .readdata(readdata), .waitrequest(waitrequest), .fifo_irq(fifo_irq)
    );

    // Reference model: stored words, words still owed by an accepted record.
    logic [31:0] m_fifo[$];
    logic [31:0] m_pend[$];
    logic [15:0] m_seq;
    logic [31:0] m_dropped, m_mask;
    logic [15:0] m_thr;
    logic        m_en, m_irq, m_pop;

    int n_cmp = 0;
    int n_err = 0;

    task automatic model_reset();
        m_fifo.delete(); m_pend.delete();
        m_seq = 0; m_dropped = 0; m_mask = '1; m_thr = 16'(DEPTH / 2);
        m_en = 0; m_irq = 0;
    endtask

    // Apply the rules for one clock edge to the model, then advance the DUT.
    task automatic cyc();
        int  sz;
        bit  busy, flush, irq_n;
        if (reset) begin
            model_reset();
        end else begin
            sz    = m_fifo.size();
            busy  = (m_pend.size() != 0);
            irq_n = (sz >= int'(m_thr));
            flush = write && (address == 8'h00) && writedata[1];
            if (flush) begin
                m_fifo.delete(); m_pend.delete();
            end else begin
                if (m_pop && sz != 0) void'(m_fifo.pop_front());
                if (busy) m_fifo.push_back(m_pend.pop_front());
                if (sample_valid && m_en && (int'(sample_motor) < NM) && m_mask[sample_motor[4:0]]) begin
                    if (busy || (DEPTH - sz) < 4) begin
                        if (m_dropped != 32'hFFFFFFFF) m_dropped++;
                    end else begin
                        m_pend.push_back({8'hA5, sample_motor, m_seq});
                        m_pend.push_back(position);
                        m_pend.push_back({velocity, current});
                        m_pend.push_back({displacement, pwm_ref});
                        m_seq++;
                    end
                end
            end
            if (write) begin
                case (address)
                    8'h00: m_en = writedata[0];
                    8'h02: m_dropped = 0;
                    8'h03: m_thr = writedata[15:0];
                    8'h04: m_mask = writedata;
                    default: ;
                endcase
            end
            m_irq = irq_n;
        end
        @(posedge clock); #1;
        sample_valid = 0;
        write = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        reset = 1; read = 0; write = 0; sample_valid = 0;
        idle(2);
        reset = 0;
    endtask

    task automatic set_sample(input logic [7:0] mot, input logic [31:0] pos,
                              input logic [15:0] vel, input logic [15:0] cur,
                              input logic [15:0] disp, input logic [15:0] pwm);
        sample_valid = 1; sample_motor = mot; position = pos;
        velocity = vel; current = cur; displacement = disp; pwm_ref = pwm;
    endtask

    task automatic pulse(input logic [7:0] mot);
        set_sample(mot, $urandom, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        cyc();
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1;
        cyc();
    endtask

    // Two-cycle read; returns DUT data, model expectation and both waitrequest samples.
    task automatic bus_read(input logic [7:0] a, output logic [31:0] got, output logic [31:0] exp,
                            output logic wq1, output logic wq2);
        bit e1;
        address = a; read = 1;
        #1 wq1 = waitrequest;
        e1 = (m_fifo.size() == 0);
        cyc();
        wq2 = waitrequest;
        got = readdata;
        case (a)
            8'h00: exp = (e1 || m_fifo.size() == 0) ? BAD : m_fifo[0];
            8'h01: exp = 32'(m_fifo.size());
            8'h02: exp = m_dropped;
            8'h03: exp = {m_thr, 14'd0, m_pend.size() != 0, m_en};
            8'h04: exp = m_mask;
            default: exp = BAD;
        endcase
        m_pop = (a == 8'h00) && !(e1 || m_fifo.size() == 0);
        cyc();
        m_pop = 0;
        read = 0;
    endtask

    task automatic test_reset();
        logic [31:0] got, exp; logic wq1, wq2;
        do_reset();
        n_cmp++; if (readdata !== 32'h0) begin n_err++; $display("FAIL reset_readdata: got %h want 00000000", readdata); end
        n_cmp++; if (fifo_irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", fifo_irq); end
        for (int a = 0; a < 6; a++) begin
            bus_read(8'(a), got, exp, wq1, wq2);
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL reset_reg%0d: got %h want %h", a, got, exp); end
            n_cmp++; if (wq1 !== 1'b1 || wq2 !== 1'b0) begin n_err++; $display("FAIL reset_waitreq%0d: got %b%b want 10", a, wq1, wq2); end
        end
        bus_read(8'h03, got, exp, wq1, wq2);
        n_cmp++; if (got !== 32'h0004_0000) begin n_err++; $display("FAIL reset_ctrl: got %h want 00040000", got); end
    endtask

    task automatic test_single_record();
        logic [31:0] got, exp; logic wq1, wq2;
        logic [31:0] want[4] = '{32'hA5020000, 32'h12345678, 32'hFFFB0064, 32'h0007FF38};
        do_reset();
        bus_write(8'h00, 32'h1);
        set_sample(8'd2, 32'h12345678, -16'sd5, 16'd100, 16'd7, -16'sd200);
        cyc();
        idle(4);
        bus_read(8'h01, got, exp, wq1, wq2);
        n_cmp++; if (got !== 32'd4 || got !== exp) begin n_err++; $display("FAIL single_level: got %0d want 4 (model %0d)", got, exp); end
        for (int i = 0; i < 4; i++) begin
            bus_read(8'h00, got, exp, wq1, wq2);
            n_cmp++; if (got !== want[i] || got !== exp) begin n_err++; $display("FAIL single_word%0d: got %h want %h", i, got, want[i]); end
        end
    endtask

    task automatic test_mask();
        logic [31:0] got, exp; logic wq1, wq2;
        do_reset();
        bus_write(8'h00, 32'h1);
        bus_write(8'h04, 32'h1);
        pulse(8'd0); idle(5);
        pulse(8'd1); idle(5);
        pulse(8'd0); idle(5);
        bus_read(8'h01, got, exp, wq1, wq2);
        n_cmp++; if (got !== 32'd8 || got !== exp) begin n_err++; $display("FAIL mask_level: got %0d want 8", got); end
        bus_read(8'h02, got, exp, wq1, wq2);
        n_cmp++; if (got !== 32'd0) begin n_err++; $display("FAIL mask_dropped: got %0d want 0", got); end
        for (int i = 0; i < 8; i++) begin
            bus_read(8'h00, got, exp, wq1, wq2);
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL mask_word%0d: got %h want %h", i, got, exp); end
            if (i % 4 == 0) begin
                n_cmp++; if (got[15:0] !== 16'(i / 4)) begin n_err++; $display("FAIL mask_seq%0d: got %0d want %0d", i, got[15:0], i / 4); end
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] got, exp; logic wq1, wq2;
        do_reset();
        bus_write(8'h00, 32'h1);
        for (int i = 0; i < 3; i++) begin pulse(8'd3); idle(9); end
        bus_read(8'h01, got, exp, wq1, wq2);
        n_cmp++; if (got !== 32'd8) begin n_err++; $display("FAIL ovf_level: got %0d want 8", got); end
        bus_read(8'h02, got, exp, wq1, wq2);
        n_cmp++; if (got !== 32'd1) begin n_err++; $display("FAIL ovf_dropped: got %0d want 1", got); end
        for (int i = 0; i < 8; i++) begin
            bus_read(8'h00, got, exp, wq1, wq2);
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL ovf_word%0d: got %h want %h", i, got, exp); end
        end
        bus_read(8'h00, got, exp, wq1, wq2);
        n_cmp++; if (got !== BAD) begin n_err++; $display("FAIL ovf_empty: got %h want deadbeef", got); end
        bus_read(8'h01, got, exp, wq1, wq2);
        n_cmp++; if (got !== 32'd0) begin n_err++; $display("FAIL ovf_level0: got %0d want 0", got); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, exp; logic wq1, wq2;
        do_reset();
        bus_write(8'h00, 32'h1);
        pulse(8'd4); cyc();
        pulse(8'd5); idle(6);
        bus_read(8'h02, got, exp, wq1, wq2);
        n_cmp++; if (got !== 32'd1 || got !== exp) begin n_err++; $display("FAIL b2b_dropped: got %0d want 1", got); end
        bus_read(8'h01, got, exp, wq1, wq2);
        n_cmp++; if (got !== 32'd4) begin n_err++; $display("FAIL b2b_level: got %0d want 4", got); end
        bus_write(8'h02, 32'h5A5A);
        bus_read(8'h02, got, exp, wq1, wq2);
        n_cmp++; if (got !== 32'd0) begin n_err++; $display("FAIL b2b_clear: got %0d want 0", got); end
    endtask

    task automatic test_flush();
        logic [31:0] got, exp; logic wq1, wq2;
        do_reset();
        bus_write(8'h00, 32'h1);
        pulse(8'd1); idle(2);
        bus_write(8'h00, 32'h3);
        bus_read(8'h01, got, exp, wq1, wq2);
        n_cmp++; if (got !== 32'd0) begin n_err++; $display("FAIL flush_level: got %0d want 0", got); end
        pulse(8'd2); idle(4);
        for (int i = 0; i < 4; i++) begin
            bus_read(8'h00, got, exp, wq1, wq2);
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL flush_word%0d: got %h want %h", i, got, exp); end
            if (i == 0) begin
                n_cmp++; if (got !== 32'hA5020001) begin n_err++; $display("FAIL flush_seq: got %h want a5020001", got); end
            end
        end
    endtask

    task automatic test_irq();
        logic [31:0] got, exp; logic wq1, wq2;
        do_reset();
        bus_write(8'h00, 32'h1);
        bus_write(8'h03, 32'h4);
        pulse(8'd0);
        for (int i = 1; i <= 6; i++) begin
            cyc();
            n_cmp++; if (fifo_irq !== m_irq) begin n_err++; $display("FAIL irq_cycle%0d: got %b want %b", i, fifo_irq, m_irq); end
            if (i == 4 || i == 5) begin
                n_cmp++; if (fifo_irq !== (i == 5)) begin n_err++; $display("FAIL irq_edge%0d: got %b want %b", i, fifo_irq, i == 5); end
            end
        end
        pulse(8'd1);
        for (int i = 0; i < 4; i++) begin
            bus_read(8'h00, got, exp, wq1, wq2);
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL irq_word%0d: got %h want %h", i, got, exp); end
            n_cmp++; if (fifo_irq !== m_irq) begin n_err++; $display("FAIL irq_pop%0d: got %b want %b", i, fifo_irq, m_irq); end
        end
        bus_read(8'h01, got, exp, wq1, wq2);
        n_cmp++; if (got !== 32'd4) begin n_err++; $display("FAIL irq_level: got %0d want 4", got); end
        bus_write(8'h04, 32'h3);
        pulse(8'd2); pulse(8'd0); cyc();
        do_reset();
        n_cmp++; if (fifo_irq !== 1'b0 || readdata !== 32'h0) begin n_err++; $display("FAIL rst_mid_out: got irq %b data %h want 0 0", fifo_irq, readdata); end
        for (int a = 1; a < 5; a++) begin
            bus_read(8'(a), got, exp, wq1, wq2);
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rst_mid_reg%0d: got %h want %h", a, got, exp); end
        end
    endtask

    task automatic test_random();
        logic [31:0] got, exp; logic wq1, wq2;
        int r;
        do_reset();
        bus_write(8'h00, 32'h1);
        for (int i = 0; i < 700; i++) begin
            r = $urandom_range(0, 99);
            if (r < 20) begin
                pulse(8'($urandom_range(0, 7)));
            end else if (r < 35) begin
                set_sample(8'($urandom_range(0, 7)), $urandom, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
                bus_read(8'h00, got, exp, wq1, wq2);
                n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rnd_overlap%0d: got %h want %h", i, got, exp); end
            end else if (r < 70) begin
                bus_read(8'h00, got, exp, wq1, wq2);
                n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rnd_data%0d: got %h want %h", i, got, exp); end
            end else if (r < 82) begin
                bus_read(8'($urandom_range(1, 5)), got, exp, wq1, wq2);
                n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rnd_reg%0d: got %h want %h", i, got, exp); end
            end else if (r < 85) begin
                bus_write(8'h04, $urandom | 32'h15);
            end else if (r < 88) begin
                bus_write(8'h03, 32'($urandom_range(0, 9)));
            end else if (r < 89) begin
                bus_write(8'h00, 32'h3);
            end else if (r < 90) begin
                bus_write(8'h02, $urandom);
            end else if (r < 92) begin
                bus_write(8'h00, 32'($urandom_range(0, 3) != 0));
            end else begin
                cyc();
            end
            n_cmp++; if (fifo_irq !== m_irq) begin n_err++; $display("FAIL rnd_irq%0d: got %b want %b", i, fifo_irq, m_irq); end
        end
    endtask

    initial begin
        m_pop = 0;
        model_reset();
        test_reset();
        test_single_record();
        test_mask();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_irq();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
